// File: rtl/digit_field_scanner.sv
// digit_field_scanner
// Walks a VGA line pixel by pixel and reports, for every consumed pixel,
// whether it lies in a digit slot or the decimal-point gap of the speed or
// heading field. For digit pixels it also gives the slot number, the glyph
// column and the BCD digit for that slot. Digits come from shadow registers
// that are loaded on frame_start, so a frame never shows a half-updated value.
// All outputs are registered: after the edge that consumes column N they
// describe column N, and they hold while pix_en is low.
// Optional feature: define DIGIT_FIELD_BLANK_LEADING_ZERO_EN to flag leading
// zeros in slots 0..1 on digit_blank. Without it digit_blank is tied to 0.
module digit_field_scanner #(
  parameter int SPD_X0  = 128,
  parameter int HDG_X0  = 384,
  parameter int GLYPH_W = 24,
  parameter int GAP_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [19:0] speed_bcd,
  input  logic [19:0] heading_bcd,
  output logic        in_digit,
  output logic        in_gap,
  output logic        field,
  output logic [2:0]  slot,
  output logic [4:0]  glyph_col,
  output logic [3:0]  digit_code,
  output logic        digit_blank
);

  localparam logic [10:0] SPD_X0_C  = 11'(SPD_X0);
  localparam logic [10:0] HDG_X0_C  = 11'(HDG_X0);
  localparam logic [10:0] COL_MAX   = 11'h7FF;
  localparam logic [4:0]  GC_LAST   = 5'(GLYPH_W - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_W - 1);

  typedef enum logic [1:0] {
    ST_OUTSIDE = 2'd0,
    ST_DIGIT   = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;
  logic        field_q, field_d;
  logic [2:0]  slot_q, slot_d;
  logic [4:0]  gc_q, gc_d;
  logic [7:0]  gap_q, gap_d;
  logic [19:0] spd_sh_q, spd_sh_d;
  logic [19:0] hdg_sh_q, hdg_sh_d;
  logic [3:0]  code_q, code_d;
  logic        blank_d;

  // Selected shadow word and the column the consumed pixel lands on.
  logic [19:0] sel_bcd;
  logic [10:0] col_adv;
  logic        go_outside;

  // Picks the digit nibble for a slot; slot 0 is the leftmost nibble.
  function automatic logic [3:0] pick_digit(input logic [19:0] v, input logic [2:0] s);
    logic [3:0] r;
    case (s)
      3'd0:    r = v[19:16];
      3'd1:    r = v[15:12];
      3'd2:    r = v[11:8];
      3'd3:    r = v[7:4];
      3'd4:    r = v[3:0];
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Shadow registers snapshot the inputs on frame_start only.
  always_comb begin
    spd_sh_d = spd_sh_q;
    hdg_sh_d = hdg_sh_q;
    if (frame_start) begin
      spd_sh_d = speed_bcd;
      hdg_sh_d = heading_bcd;
    end
  end

  // Column counter, field walker and registered output decode.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    field_d    = field_q;
    slot_d     = slot_q;
    gc_d       = gc_q;
    gap_d      = gap_q;
    code_d     = code_q;
    blank_d    = 1'b0;
    col_adv    = col_q;
    go_outside = 1'b0;
    sel_bcd    = spd_sh_q;

    if (pix_en) begin
      if (line_start) begin
        col_adv = 11'd0;
      end else if (col_q == COL_MAX) begin
        col_adv = col_q;
      end else begin
        col_adv = col_q + 11'd1;
      end
      col_d = col_adv;

      case (state_q)
        ST_DIGIT: begin
          if (line_start) begin
            go_outside = 1'b1;
          end else if (gc_q == GC_LAST) begin
            gc_d = 5'd0;
            if (slot_q == 3'd2) begin
              state_d = ST_GAP;
              slot_d  = 3'd0;
              gap_d   = 8'd0;
            end else if (slot_q == 3'd4) begin
              go_outside = 1'b1;
            end else begin
              slot_d = slot_q + 3'd1;
            end
          end else begin
            gc_d = gc_q + 5'd1;
          end
        end
        ST_GAP: begin
          if (line_start) begin
            go_outside = 1'b1;
          end else if (gap_q == GAP_LAST) begin
            state_d = ST_DIGIT;
            slot_d  = 3'd3;
            gc_d    = 5'd0;
            gap_d   = 8'd0;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        default: go_outside = 1'b1;
      endcase

      // Leaving a field (or idling outside) re-checks the field entry points
      // so back-to-back fields would still be picked up.
      if (go_outside) begin
        state_d = ST_OUTSIDE;
        field_d = 1'b0;
        slot_d  = 3'd0;
        gc_d    = 5'd0;
        gap_d   = 8'd0;
        if (col_adv == SPD_X0_C) begin
          state_d = ST_DIGIT;
        end else if (col_adv == HDG_X0_C) begin
          state_d = ST_DIGIT;
          field_d = 1'b1;
        end
      end

      // Digit code uses the pre-edge shadow so a simultaneous frame_start
      // only affects the following pixel.
      sel_bcd = field_d ? hdg_sh_q : spd_sh_q;
      if (state_d == ST_DIGIT) begin
        code_d = pick_digit(sel_bcd, slot_d);
      end else begin
        code_d = 4'd0;
      end
`ifdef DIGIT_FIELD_BLANK_LEADING_ZERO_EN
      blank_d = (state_d == ST_DIGIT) &&
                (((slot_d == 3'd0) && (sel_bcd[19:16] == 4'd0)) ||
                 ((slot_d == 3'd1) && (sel_bcd[19:12] == 8'd0)));
`else
      blank_d = 1'b0;
`endif
    end
  end

`ifdef DIGIT_FIELD_BLANK_LEADING_ZERO_EN
  logic blank_q;

  // Leading-zero flag, held with the rest of the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else if (pix_en) begin
      blank_q <= blank_d;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 1'b0;
`endif

  // State, counters and shadow registers; reset parks the column saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OUTSIDE;
      col_q    <= COL_MAX;
      field_q  <= 1'b0;
      slot_q   <= 3'd0;
      gc_q     <= 5'd0;
      gap_q    <= 8'd0;
      spd_sh_q <= 20'd0;
      hdg_sh_q <= 20'd0;
      code_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      field_q  <= field_d;
      slot_q   <= slot_d;
      gc_q     <= gc_d;
      gap_q    <= gap_d;
      spd_sh_q <= spd_sh_d;
      hdg_sh_q <= hdg_sh_d;
      code_q   <= code_d;
    end
  end

  assign in_digit   = (state_q == ST_DIGIT);
  assign in_gap     = (state_q == ST_GAP);
  assign field      = field_q;
  assign slot       = slot_q;
  assign glyph_col  = gc_q;
  assign digit_code = code_q;

endmodule
